stage5_wb_buf: RTL

Parametrised write-back stage for the five-stage MIPS pipeline. It sits between the MEM/WB boundary and the register-file write port and holds one buffered result under a valid/ready handshake, so the register-file port can stall without losing an instruction. It performs load-data alignment and extension for byte/half/word/full-width loads, and suppresses writes to register 0 and misaligned loads. It also provides a forwarding tap, diagnostic outputs and a retired-instruction counter.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/stage5_wb_buf_if.sv | 38 +++
 rtl/wb_load_align.sv | 55 +++++
 rtl/stage5_wb_buf.sv | 104 ++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   ldsize_e   : load width selector (byte / half / word / full datapath)
//   size_bytes : number of bytes a load of a given size occupies
package wb_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ldsize_e;

    // LD_W on a 32-bit build is already the full datapath, so it and LD_D
    // both come out as 4 bytes there.
    function automatic int unsigned size_bytes(input ldsize_e sz, input int unsigned data_w);
        int unsigned n;
        case (sz)
            LD_B:    n = 1;
            LD_H:    n = 2;
            LD_W:    n = 4;
            default: n = data_w / 8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stage5_wb_buf_if.sv
// MEM->WB handshake bus plus the register-file write port.
// Latency: n/a (signal bundle).
// Backpressure: in_valid/in_ready on the MEM side, rf_ready on the register-file side.
//   master : MEM stage + register file (drives in_*, rf_ready; sees in_ready, rf_*)
//   slave  : write-back buffer
interface stage5_wb_buf_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OFF_W  = $clog2(DATA_W / 8)
);
    logic              in_valid;
    logic              in_ready;
    logic              in_regwrite;
    logic              in_memtoreg;
    logic [1:0]        in_ldsize;
    logic              in_ldsign;
    logic [OFF_W-1:0]  in_addr_lo;
    logic [DATA_W-1:0] in_rdata;
    logic [DATA_W-1:0] in_alurslt;
    logic [REG_AW-1:0] in_wrreg;

    logic              rf_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output in_valid, in_regwrite, in_memtoreg, in_ldsize, in_ldsign,
               in_addr_lo, in_rdata, in_alurslt, in_wrreg, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, in_regwrite, in_memtoreg, in_ldsize, in_ldsign,
               in_addr_lo, in_rdata, in_alurslt, in_wrreg, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_load_align.sv
// Extracts the addressed byte/half/word/full field from a memory word and extends it.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//   rdata, addr_lo, ldsize, ldsign -> aligned (extended load value), misaligned
module wb_load_align
    import wb_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  addr_lo,
    input  ldsize_e           ldsize,
    input  logic              ldsign,
    output logic [DATA_W-1:0] aligned,
    output logic              misaligned
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;

    always_comb begin
        // Bring the addressed field down to bit 0, then keep only its width.
        shifted = rdata >> {addr_lo, 3'b000};

        case (ldsize)
            LD_B: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = shifted[7];
            end
            LD_H: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            LD_W: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = shifted[DATA_W-1];
            end
        endcase

        aligned = shifted & keep_mask;
        if (ldsign && sign_bit) begin
            aligned = aligned | ~keep_mask;
        end

        // Sizes are powers of two, so "offset not a multiple of size" is a low-bit test.
        misaligned = (addr_lo & OFF_W'(size_bytes(ldsize, DATA_W) - 1)) != '0;
    end

endmodule

// File: rtl/stage5_wb_buf.sv
// Write-back stage: one-entry result buffer feeding the register-file write port.
// Latency: an instruction accepted on edge N drives rf_we/rf_wdata during cycle N+1.
// Backpressure: in_ready = !full || retire; a pending write stalls while rf_ready is low.
//   bus          : MEM-side handshake and register-file write port (slave modport)
//   fwd_*        : forwarding tap, mirrors the register-file write
//   wb_regdata/wb_regwrite : diagnostic copies of rf_wdata/rf_we
//   retire_count : retired instructions (wraps), misalign_err : sticky misaligned-load flag
module stage5_wb_buf
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    stage5_wb_buf_if.slave    bus,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] wb_regdata,
    output logic              wb_regwrite,
    output logic [CNT_W-1:0]  retire_count,
    output logic              misalign_err
);

    typedef struct packed {
        logic              regwrite;
        logic [REG_AW-1:0] wrreg;
        logic              misalign;
    } meta_t;

    logic              full;
    meta_t             meta_q;
    meta_t             meta_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] ld_data;
    logic              ld_misaligned;
    logic              rf_we_i;
    logic              retire;
    logic              accept;

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata      (bus.in_rdata),
        .addr_lo    (bus.in_addr_lo),
        .ldsize     (ldsize_e'(bus.in_ldsize)),
        .ldsign     (bus.in_ldsign),
        .aligned    (ld_data),
        .misaligned (ld_misaligned)
    );

    // Entries that will not write (no regwrite, r0, misaligned) leave without
    // waiting on the register file, so only a real write can stall the stage.
    assign rf_we_i      = full && meta_q.regwrite && (meta_q.wrreg != '0) && !meta_q.misalign;
    assign retire       = full && (bus.rf_ready || !rf_we_i);
    assign bus.in_ready = !full || retire;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        meta_d          = '0;
        meta_d.regwrite = bus.in_regwrite;
        meta_d.wrreg    = bus.in_wrreg;
        meta_d.misalign = bus.in_memtoreg && ld_misaligned;
        data_d          = bus.in_memtoreg ? ld_data : bus.in_alurslt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full         <= 1'b0;
            meta_q       <= '0;
            data_q       <= '0;
            retire_count <= '0;
            misalign_err <= 1'b0;
        end else begin
            // Accept has priority: a same-cycle retire+accept simply reloads.
            if (accept) begin
                full   <= 1'b1;
                meta_q <= meta_d;
                data_q <= data_d;
            end else if (retire) begin
                full <= 1'b0;
            end
            if (retire) begin
                retire_count <= retire_count + CNT_W'(1);
            end
            if (accept && meta_d.misalign) begin
                misalign_err <= 1'b1;
            end
        end
    end

    assign bus.rf_we    = rf_we_i;
    assign bus.rf_waddr = meta_q.wrreg;
    assign bus.rf_wdata = data_q;
    assign fwd_valid    = rf_we_i;
    assign fwd_reg      = meta_q.wrreg;
    assign fwd_data     = data_q;
    assign wb_regdata   = data_q;
    assign wb_regwrite  = rf_we_i;

endmodule
